// File: rtl/nfifo_rd_sched.sv
// nfifo_rd_sched: round-robin burst read scheduler for the multi-flow NFIFO.
// It tags every word leaving the buffer with its source flow.
module nfifo_rd_sched #(
  parameter int FLOWS = 4,
  parameter int BURST_LEN = 8,
  parameter int READ_LAT = 1,
  localparam int FW = FLOWS > 1 ? $clog2(FLOWS) : 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [FLOWS-1:0] EMPTY,
  output logic [FW-1:0]    RD_BLK_ADDR,
  output logic             READ,
  output logic             PIPE_EN,
  input  logic             DATA_VLD,
  output logic             OUT_SRC_RDY,
  output logic [FW-1:0]    OUT_FLOW,
  input  logic             OUT_DST_RDY,
  output logic             ACTIVE
);
  localparam int CW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
  localparam logic [FW-1:0] LAST_FLOW = FW'(FLOWS - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(BURST_LEN - 1);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_nx;
  logic [FW-1:0] rr, rr_nx, sel, sel_nx, pick;
  logic [CW-1:0] cnt, cnt_nx;
  logic [FW:0] idx;
  logic found, done;
  logic [FW-1:0] tag [READ_LAT];
  // first non-empty flow at or after rr, wrapping past FLOWS-1
  always_comb begin
    found = 1'b0;
    pick = '0;
    idx = '0;
    for (int i = 0; i < FLOWS; i++) begin
      idx = {1'b0, rr} + (FW+1)'(i);
      if (idx >= (FW+1)'(FLOWS)) idx = idx - (FW+1)'(FLOWS);
      if (!found && !EMPTY[idx[FW-1:0]]) begin
        found = 1'b1;
        pick = idx[FW-1:0];
      end
    end
  end
  assign PIPE_EN = OUT_DST_RDY & ~RESET;
  assign ACTIVE = state == BURST;
  assign RD_BLK_ADDR = ACTIVE ? sel : '0;
  assign READ = ACTIVE & PIPE_EN & ~EMPTY[sel];
  assign done = (READ & (cnt == LAST_CNT)) | (EMPTY[sel] & ~READ);
  assign OUT_SRC_RDY = DATA_VLD;
  assign OUT_FLOW = tag[READ_LAT-1];
  always_comb begin
    state_nx = state;
    sel_nx = sel;
    cnt_nx = cnt;
    rr_nx = rr;
    if (state == IDLE) begin
      state_nx = found ? BURST : IDLE;
      sel_nx = found ? pick : sel;
      cnt_nx = found ? '0 : cnt;
    end else begin
      cnt_nx = READ ? cnt + 1'b1 : cnt;
      state_nx = done ? IDLE : BURST;
      rr_nx = done ? (sel == LAST_FLOW ? '0 : sel + 1'b1) : rr;
    end
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      rr <= '0;
      sel <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      rr <= rr_nx;
      sel <= sel_nx;
      cnt <= cnt_nx;
    end
  end
  // tags move in lockstep with the buffer's read pipeline
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int k = 0; k < READ_LAT; k++) tag[k] <= '0;
    end else if (PIPE_EN) begin
      if (READ) tag[0] <= RD_BLK_ADDR;
      for (int k = 1; k < READ_LAT; k++) tag[k] <= tag[k-1];
    end
  end
endmodule

// File: doc/nfifo_rd_sched.md
Name: nfifo_rd_sched

Overview:
- Read-side scheduler for the multi-flow NFIFO buffer. Sequences the buffer's read interface: picks a non-empty flow, drives the read block address, READ and PIPE_EN.
- Services flows round-robin in bursts of up to BURST_LEN words.
- Tags each word leaving the buffer with its flow number so a single downstream consumer can demultiplex.

Parameters:
- FLOWS, 4, number of NFIFO flows (2..64).
- BURST_LEN, 8, maximum words read from one flow per grant (1..256).
- READ_LAT, 1, NFIFO read latency in PIPE_EN-enabled cycles (1 without output register, 2 with).

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RESET  in  1  synchronous reset, active-high.
- EMPTY  in  FLOWS  per-flow empty flags from NFIFO.
- RD_BLK_ADDR  out  FW=max(1,clog2(FLOWS))  flow selected for read.
- READ  out  1  read strobe to NFIFO.
- PIPE_EN  out  1  NFIFO read pipeline enable.
- DATA_VLD  in  1  NFIFO output data valid.
- OUT_SRC_RDY  out  1  output word valid (= DATA_VLD).
- OUT_FLOW  out  FW  flow number of the current output word.
- OUT_DST_RDY  in  1  downstream can accept a word.
- ACTIVE  out  1  a burst grant is currently held.

Behaviour:
- Reset: state IDLE, rr pointer 0, burst counter 0, sel 0, flow-tag pipe cleared. Outputs: READ=0, RD_BLK_ADDR=0, ACTIVE=0, OUT_FLOW=0. PIPE_EN is forced to 0 while RESET=1.
- PIPE_EN = OUT_DST_RDY (when not in reset). OUT_SRC_RDY = DATA_VLD (combinational pass).
- IDLE:
  - If any EMPTY bit is 0, choose the first flow with EMPTY=0, searching from rr pointer upward with wrap FLOWS-1 -> 0.
  - Register it into sel, clear the counter, go to BURST next cycle.
  - READ=0 in IDLE, so grant latency is 1 cycle.
- BURST:
  - RD_BLK_ADDR=sel, ACTIVE=1.
  - READ = PIPE_EN & ~EMPTY[sel].
  - Counter increments on READ.
- Leave BURST for IDLE when either:
  - READ=1 and counter = BURST_LEN-1; or
  - EMPTY[sel]=1 and READ=0.
  - On exit, rr pointer = sel+1 modulo FLOWS (wrap for non-power-of-2 FLOWS).
- PIPE_EN=0 in BURST: state, counter and tags hold; no timeout.
- Fairness: a flow that stays non-empty is granted at least once per FLOWS grants.
- Flow-tag pipe:
  - READ_LAT registers, all advancing only when PIPE_EN=1.
  - Stage 0 loads RD_BLK_ADDR when READ=1.
  - OUT_FLOW = last stage, so it is valid whenever DATA_VLD=1.
- Boundaries:
  - All flows empty: remain in IDLE, READ never asserted.
  - FLOWS=2: the search must still wrap.
  - BURST_LEN=1: exactly one word per grant.
  - Simultaneous last-burst READ and EMPTY[sel] rising: the exit occurs once, and the pointer advances once.
- RESET mid-burst: the next cycle is IDLE with the pointer at 0. Words in flight in NFIFO are the buffer's concern; tag pipe is cleared.

Test Plan:
- FLOWS=4, BURST_LEN=8, 20 words pre-loaded in flow 2 only, OUT_DST_RDY=1 -> READ bursts 8,8,4 on addr 2 with one idle cycle between bursts; every output has OUT_FLOW=2.
- All four flows hold 3 words, BURST_LEN=8 -> service order 0,1,2,3; exactly 3 reads each; exit on empty; ACTIVE drops between grants.
- Flows 1 and 3 continuously non-empty, BURST_LEN=2 -> alternating grants 1,3,1,3; each grant is exactly 2 READ pulses.
- OUT_DST_RDY toggled in a pseudo-random pattern, READ_LAT=2 -> READ only while PIPE_EN=1; OUT_FLOW matches the scoreboard for each DATA_VLD word; no word lost or duplicated.
- RESET asserted for 1 cycle in the middle of a burst on flow 3 -> the next cycle has READ=0 and ACTIVE=0; the next grant searches from flow 0.
- All EMPTY=1 for 100 cycles -> READ=0 and ACTIVE=0 throughout; state stays IDLE.
